// File: rtl/univ_counter_chk_pkg.sv
// Shared types and constants for the universal binary counter checker.
package univ_counter_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2
    } chk_state_t;

    localparam int KIND_Q   = 0;
    localparam int KIND_MAX = 1;
    localparam int KIND_MIN = 2;

    function automatic longint unsigned all_ones(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/univ_counter_model.sv
// Combinational next-value model of univ_bin_counter.
module univ_counter_model #(
    parameter int N = 3
) (
    input  logic [N-1:0] v,
    input  logic         syn_clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [N-1:0] d,
    output logic [N-1:0] nxt
);

    always_comb begin
        nxt = v;
        if (syn_clr)
            nxt = '0;
        else if (load)
            nxt = d;
        else if (en && up)
            nxt = v + 1'b1;
        else if (en)
            nxt = v - 1'b1;
    end

endmodule

// File: rtl/univ_counter_checker.sv
// Passive cycle-accurate checker for univ_bin_counter with first-failure capture.
module univ_counter_checker
    import univ_counter_chk_pkg::*;
#(
    parameter int N     = 3,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             arm,
    input  logic             resync,
    input  logic             syn_clr,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic [N-1:0]     d,
    input  logic [N-1:0]     q,
    input  logic             max_tick,
    input  logic             min_tick,
    output logic             active,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [N-1:0]     first_q,
    output logic [N-1:0]     first_exp,
    output logic [2:0]       first_kind
);

    localparam logic [N-1:0]     MAX_V   = N'(all_ones(N));
    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(all_ones(ERR_W));

    chk_state_t   state;
    chk_state_t   state_nxt;
    logic [N-1:0] exp_q;
    logic [N-1:0] exp_nxt;
    logic [N-1:0] base;
    logic [2:0]   kind;
    logic         cmp;
    logic         mism;

    // SYNC re-acquires from the live counter, CHECK free-runs on exp
    assign base = (state == SYNC) ? q : exp_q;

    univ_counter_model #(.N(N)) u_model (
        .v       (base),
        .syn_clr (syn_clr),
        .load    (load),
        .en      (en),
        .up      (up),
        .d       (d),
        .nxt     (exp_nxt)
    );

    always_comb begin
        state_nxt = state;
        if (!arm) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_nxt = SYNC;
                SYNC:    state_nxt = CHECK;
                CHECK:   state_nxt = resync ? SYNC : CHECK;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        kind           = '0;
        kind[KIND_Q]   = (q != exp_q);
        kind[KIND_MAX] = (max_tick != (exp_q == MAX_V));
        kind[KIND_MIN] = (min_tick != (exp_q == '0));
    end

    assign cmp    = arm && !resync && (state == CHECK);
    assign mism   = cmp && (kind != 3'b000);
    assign active = (state == CHECK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            exp_q <= '0;
        else if (state != IDLE)
            exp_q <= exp_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err        <= 1'b0;
            err_cnt    <= '0;
            first_q    <= '0;
            first_exp  <= '0;
            first_kind <= '0;
        end else if (mism) begin
            err <= 1'b1;
            if (err_cnt != ERR_MAX)
                err_cnt <= err_cnt + 1'b1;
            if (!err) begin
                first_q    <= q;
                first_exp  <= exp_q;
                first_kind <= kind;
            end
        end
    end

endmodule
